seq_mul32_ctrl: RTL

Sequential 32x32 -> 64-bit multiplier controller built around one instance of the team's 32-bit `adder_substractor32`. It time-shares that single adder for operand negation, 32 shift-add iterations and result negation. It supports signed (two's complement) and unsigned operands and has a fixed 36-cycle latency. It sits beside the ALU as the multi-cycle MUL unit, using a start/busy/done handshake.

---
 rtl/seq_mul32_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_mul32_ctrl.sv
// Sequential 32x32->64 multiplier: one shared 32-bit adder/subtractor does operand negation,
// 32 shift-add steps and result negation, with a fixed 36-cycle start-to-done latency.

module adder_substractor32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        m,
  output logic [31:0] s,
  output logic        c,
  output logic        v
);
  logic [31:0] b_eff;

  // m=1 computes a - b as a + ~b + 1
  assign b_eff  = b ^ {32{m}};
  assign {c, s} = {1'b0, a} + {1'b0, b_eff} + {32'b0, m};
  assign v      = (a[31] == b_eff[31]) && (s[31] != a[31]);
endmodule

module seq_mul32_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [2:0] {StIdle, StNegA, StNegB, StMul, StNegLo, StNegHi} state_e;

  state_e      state;
  logic [31:0] mcand;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        neg_res;
  logic        sgn;
  logic        lo_zero;
  logic [4:0]  cnt;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_m;
  logic [31:0] add_s;
  logic        add_c;
  logic        add_v_unused;

  always_comb begin
    add_a = '0;
    add_b = '0;
    add_m = 1'b0;
    case (state)
      StNegA:  begin add_b = mcand; add_m = 1'b1; end
      StNegB:  begin add_b = p_lo;  add_m = 1'b1; end
      StMul:   begin add_a = p_hi;  add_b = mcand; end
      StNegLo: begin add_b = p_lo;  add_m = 1'b1; end
      // ~p_hi when a borrow propagates out of the low word, -p_hi otherwise
      StNegHi: begin add_a = lo_zero ? 32'h0 : 32'hFFFF_FFFF; add_b = p_hi; add_m = 1'b1; end
      default: ;
    endcase
  end

  adder_substractor32 u_adder (
    .a (add_a),
    .b (add_b),
    .m (add_m),
    .s (add_s),
    .c (add_c),
    .v (add_v_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      mcand   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      neg_res <= 1'b0;
      sgn     <= 1'b0;
      lo_zero <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            mcand   <= a;
            p_lo    <= b;
            p_hi    <= '0;
            neg_res <= is_signed & (a[31] ^ b[31]);
            sgn     <= is_signed;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= StNegA;
          end
        end
        StNegA: begin
          if (sgn && mcand[31]) mcand <= add_s;
          state <= StNegB;
        end
        StNegB: begin
          if (sgn && p_lo[31]) p_lo <= add_s;
          state <= StMul;
        end
        StMul: begin
          if (p_lo[0]) {p_hi, p_lo} <= {add_c, add_s, p_lo[31:1]};
          else         {p_hi, p_lo} <= {1'b0, p_hi, p_lo[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= StNegLo;
        end
        StNegLo: begin
          if (neg_res) begin
            lo_zero <= (p_lo == 32'h0);
            p_lo    <= add_s;
          end
          state <= StNegHi;
        end
        StNegHi: begin
          if (neg_res) begin
            p_hi    <= add_s;
            product <= {add_s, p_lo};
          end else begin
            product <= {p_hi, p_lo};
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule
